// File: rtl/eq_pkg.sv
// Shared types and constants for the EQ biquad engine.
// Coefficients are signed Q4.28; samples are signed 16-bit.
package eq_pkg;
   localparam int DATA_W  = 16;
   localparam int COEF_W  = 32;
   localparam int FRAC    = 28;
   localparam int ACC_W   = 64;
   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

   typedef enum logic [2:0] {
      COEF_A0 = 3'd0,
      COEF_A1 = 3'd1,
      COEF_A2 = 3'd2,
      COEF_B1 = 3'd3,
      COEF_B2 = 3'd4
   } coef_sel_t;

   typedef enum logic [1:0] {IDLE, MAC, WB, BYP} state_t;
endpackage

// File: rtl/eq_mac_unit.sv
// Shared multiply-accumulate for all biquad taps, with a saturating
// fixed-point readout of the accumulator.
module eq_mac_unit #(
   parameter int DATA_W = eq_pkg::DATA_W,
   parameter int COEF_W = eq_pkg::COEF_W,
   parameter int FRAC   = eq_pkg::FRAC
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     sub,
   input  logic signed [DATA_W-1:0] operand,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [DATA_W-1:0] y
);
   import eq_pkg::*;

   localparam int PW = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
   localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_x, acc, shifted;

   assign prod    = operand * coef;
   assign prod_x  = {{(ACC_W-PW){prod[PW-1]}}, prod};
   assign shifted = acc >>> FRAC;

   always_ff @(posedge i_clk) begin
      if (i_rst || clr) acc <= '0;
      else if (en)      acc <= sub ? acc - prod_x : acc + prod_x;
   end

   // In-range values take the plain bit slice, i.e. truncation toward -inf.
   always_comb begin
      y = acc[FRAC+DATA_W-1:FRAC];
      if (shifted > HI)      y = DATA_W'(SAT_MAX);
      else if (shifted < LO) y = DATA_W'(SAT_MIN);
   end
endmodule

// File: rtl/eq_biquad_sequencer.sv
// Time-multiplexed cascade of direct-form-I biquads sharing one MAC.
// Each stage takes 5 MAC cycles plus one writeback cycle.
module eq_biquad_sequencer #(
   parameter int NUM_STAGES = 2,
   parameter int DATA_W     = eq_pkg::DATA_W,
   parameter int COEF_W     = eq_pkg::COEF_W,
   parameter int FRAC       = eq_pkg::FRAC
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_enable,
   input  logic                     i_clear,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_data,
   output logic                     o_ready,
   output logic [(NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1)-1:0] o_coef_stage,
   output logic [2:0]               o_coef_sel,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic signed [DATA_W-1:0] o_data,
   output logic                     o_valid,
   output logic                     o_overrun
);
   import eq_pkg::*;

   localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [STG_W-1:0] LAST_S = STG_W'(NUM_STAGES - 1);

   state_t                   state_q, state_d;
   coef_sel_t                k_q;
   logic [STG_W-1:0]         s_q;
   logic signed [DATA_W-1:0] x_q, operand, y;
   logic signed [DATA_W-1:0] x_d1 [NUM_STAGES];
   logic signed [DATA_W-1:0] x_d2 [NUM_STAGES];
   logic signed [DATA_W-1:0] y_d1 [NUM_STAGES];
   logic signed [DATA_W-1:0] y_d2 [NUM_STAGES];
   logic                     last_stage, mac_clr, mac_en, mac_sub;

   assign last_stage = (s_q == LAST_S);
   assign o_overrun  = i_valid && !o_ready && !i_rst;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) state_q <= IDLE;
      else                  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_valid) state_d = i_enable ? MAC : BYP;
         MAC:     if (k_q == COEF_B2) state_d = WB;
         WB:      state_d = last_stage ? IDLE : MAC;
         BYP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_ready      = (state_q == IDLE);
      o_coef_stage = '0;
      o_coef_sel   = 3'd0;
      mac_en       = 1'b0;
      mac_sub      = 1'b0;
      mac_clr      = 1'b0;
      case (state_q)
         IDLE: mac_clr = i_valid;
         MAC: begin
            o_coef_stage = s_q;
            o_coef_sel   = k_q;
            mac_en       = 1'b1;
            mac_sub      = (k_q == COEF_B1) || (k_q == COEF_B2);
         end
         WB:      mac_clr = !last_stage;
         default: ;
      endcase
   end

   always_comb begin
      case (k_q)
         COEF_A1: operand = x_d1[s_q];
         COEF_A2: operand = x_d2[s_q];
         COEF_B1: operand = y_d1[s_q];
         COEF_B2: operand = y_d2[s_q];
         default: operand = x_q;
      endcase
   end

   eq_mac_unit #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC)) u_mac (
      .i_clk   (i_clk),
      .i_rst   (i_rst || i_clear),
      .clr     (mac_clr),
      .en      (mac_en),
      .sub     (mac_sub),
      .operand (operand),
      .coef    (i_coef),
      .y       (y)
   );

   // Clear flushes history but leaves o_data holding the last result.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            x_d1[i] <= '0;
            x_d2[i] <= '0;
            y_d1[i] <= '0;
            y_d2[i] <= '0;
         end
         k_q     <= COEF_A0;
         s_q     <= '0;
         x_q     <= '0;
         o_valid <= 1'b0;
         if (i_rst) o_data <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state_q)
            IDLE: if (i_valid) begin
               x_q <= i_data;
               k_q <= COEF_A0;
               s_q <= '0;
            end
            MAC: k_q <= (k_q == COEF_B2) ? COEF_A0 : coef_sel_t'(k_q + 3'd1);
            WB: begin
               x_d2[s_q] <= x_d1[s_q];
               x_d1[s_q] <= x_q;
               y_d2[s_q] <= y_d1[s_q];
               y_d1[s_q] <= y;
               if (!last_stage) begin
                  x_q <= y;
                  s_q <= s_q + 1'b1;
               end else begin
                  o_data  <= y;
                  o_valid <= 1'b1;
               end
            end
            BYP: begin
               o_data  <= x_q;
               o_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
